// File: rtl/tx_request_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ pulsed request channels.
// Latency: request pulse -> pending next cycle -> tx_start one cycle after that (idle, tx_busy low).
// Backpressure: tx_busy holds off grants; requests are latched per channel, and extra ones are flagged in overflow.
module tx_request_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_pulse,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [NUM_REQ-1:0]            pending,
  output logic [NUM_REQ-1:0]            overflow,
  input  logic                          ovf_clear
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         last_grant, last_grant_d;
  logic                  tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_d;
  logic [GW-1:0]         grant_id_d;
  logic [NUM_REQ-1:0]    pending_d;
  logic [NUM_REQ-1:0]    overflow_d;

  logic                  win_found;
  logic [GW-1:0]         win_idx;
  logic [GW-1:0]         cand;
  logic                  grant_fire;
  logic [NUM_REQ-1:0]    grant_vec;
  logic [DATA_WIDTH-1:0] win_data;

  // Round-robin search: first pending channel after last_grant, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!win_found && pending[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Byte of the winning channel, captured only on the grant edge.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == GW'(i)) begin
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_fire = (state_q == IDLE) && win_found && !tx_busy;

  // One-hot of the channel being granted this cycle (zero when no grant).
  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_vec[i] = grant_fire && (win_idx == GW'(i));
    end
  end

  // Request capture and overflow tracking; a pulse in the grant cycle re-arms
  // the channel instead of being lost, and a new overflow beats ovf_clear.
  always_comb begin
    pending_d  = pending;
    overflow_d = overflow;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) begin
        pending_d[i] = req_pulse[i];
      end else if (req_pulse[i]) begin
        pending_d[i] = 1'b1;
      end
      overflow_d[i] = (req_pulse[i] && pending[i] && !grant_vec[i]) ||
                      (overflow[i] && !ovf_clear);
    end
  end

  // Next-state and registered-output logic for the transmit handshake.
  always_comb begin
    state_d      = state_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data;
    grant_id_d   = grant_id;
    last_grant_d = last_grant;
    case (state_q)
      IDLE: begin
        if (grant_fire) begin
          tx_start_d   = 1'b1;
          tx_data_d    = win_data;
          grant_id_d   = win_idx;
          last_grant_d = win_idx;
          state_d      = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset parks last_grant on the top channel so
  // channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      pending    <= '0;
      overflow   <= '0;
    end else begin
      state_q    <= state_d;
      tx_start   <= tx_start_d;
      tx_data    <= tx_data_d;
      grant_id   <= grant_id_d;
      last_grant <= last_grant_d;
      pending    <= pending_d;
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_tx_request_arbiter.sv
// Self-checking bench for tx_request_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// Cycle-accurate vector table plus hand sequences for burst service and mid-frame reset.
// Outputs are sampled 1 time unit after each rising edge.
module tb_tx_request_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_pulse;
  logic [31:0] req_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic [3:0]  pending;
  logic [3:0]  overflow;
  logic        ovf_clear;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] pulse;
    logic       busy;
    logic       clr;
    logic       start;
    logic [7:0] data;
    logic [1:0] gid;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;

  vec_t vecs[$];

  tx_request_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_pulse (req_pulse),
    .req_data  (req_data),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] p, input logic b, input logic c, input logic s,
                     input logic [7:0] d, input logic [1:0] g, input logic [3:0] pe,
                     input logic [3:0] o);
    vec_t v;
    v.pulse = p; v.busy = b; v.clr = c; v.start = s;
    v.data = d; v.gid = g; v.pend = pe; v.ovf = o;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic s, input logic [7:0] d,
                         input logic [1:0] g, input logic [3:0] pe, input logic [3:0] o);
    chk({tag, " tx_start"}, 32'(tx_start), 32'(s));
    chk({tag, " tx_data"},  32'(tx_data),  32'(d));
    chk({tag, " grant_id"}, 32'(grant_id), 32'(g));
    chk({tag, " pending"},  32'(pending),  32'(pe));
    chk({tag, " overflow"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    logic [7:0] frames[$];
    logic [7:0] exp_bytes[4];
    int         start_cyc;
    int         viol;
    logic       in_frame;
    logic       seen_busy;
    logic       busy_now;

    // pulse busy clr | start data gid pending overflow
    // plain single request on ch0
    add(4'b0001, 0, 0, 0, 8'h00, 2'd0, 4'b0001, 4'b0000);
    add(4'b0000, 0, 0, 1, 8'h41, 2'd0, 4'b0000, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h41, 2'd0, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 8'h41, 2'd0, 4'b0000, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h41, 2'd0, 4'b0000, 4'b0000);
    // fairness: ch2 granted while ch1/ch3 arrive -> ch3 then ch1
    add(4'b0100, 0, 0, 0, 8'h41, 2'd0, 4'b0100, 4'b0000);
    add(4'b1010, 0, 0, 1, 8'h43, 2'd2, 4'b1010, 4'b0000);
    add(4'b0000, 1, 0, 0, 8'h43, 2'd2, 4'b1010, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h43, 2'd2, 4'b1010, 4'b0000);
    add(4'b0000, 0, 0, 1, 8'h44, 2'd3, 4'b0010, 4'b0000);
    add(4'b0000, 1, 0, 0, 8'h44, 2'd3, 4'b0010, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h44, 2'd3, 4'b0010, 4'b0000);
    add(4'b0000, 0, 0, 1, 8'h42, 2'd1, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 8'h42, 2'd1, 4'b0000, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h42, 2'd1, 4'b0000, 4'b0000);
    // overflow on ch1 during a ch0 frame, then clear
    add(4'b0001, 0, 0, 0, 8'h42, 2'd1, 4'b0001, 4'b0000);
    add(4'b0010, 0, 0, 1, 8'h41, 2'd0, 4'b0010, 4'b0000);
    add(4'b0010, 1, 0, 0, 8'h41, 2'd0, 4'b0010, 4'b0010);
    add(4'b0010, 1, 0, 0, 8'h41, 2'd0, 4'b0010, 4'b0010);
    add(4'b0000, 0, 0, 0, 8'h41, 2'd0, 4'b0010, 4'b0010);
    add(4'b0000, 0, 1, 1, 8'h42, 2'd1, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 8'h42, 2'd1, 4'b0000, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h42, 2'd1, 4'b0000, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h42, 2'd1, 4'b0000, 4'b0000);
    // ch2 pulse in its own grant cycle is kept, second frame follows
    add(4'b0100, 0, 0, 0, 8'h42, 2'd1, 4'b0100, 4'b0000);
    add(4'b0100, 0, 0, 1, 8'h43, 2'd2, 4'b0100, 4'b0000);
    add(4'b0000, 1, 0, 0, 8'h43, 2'd2, 4'b0100, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h43, 2'd2, 4'b0100, 4'b0000);
    add(4'b0000, 0, 0, 1, 8'h43, 2'd2, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 8'h43, 2'd2, 4'b0000, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h43, 2'd2, 4'b0000, 4'b0000);
    // busy in IDLE blocks grants; overflow set beats simultaneous clear
    add(4'b1000, 0, 0, 0, 8'h43, 2'd2, 4'b1000, 4'b0000);
    add(4'b1000, 1, 0, 0, 8'h43, 2'd2, 4'b1000, 4'b1000);
    add(4'b1000, 1, 1, 0, 8'h43, 2'd2, 4'b1000, 4'b1000);
    add(4'b0000, 1, 1, 0, 8'h43, 2'd2, 4'b1000, 4'b0000);
    add(4'b0000, 0, 0, 1, 8'h44, 2'd3, 4'b0000, 4'b0000);
    add(4'b0000, 1, 0, 0, 8'h44, 2'd3, 4'b0000, 4'b0000);
    add(4'b0000, 0, 0, 0, 8'h44, 2'd3, 4'b0000, 4'b0000);

    req_data  = {8'h44, 8'h43, 8'h42, 8'h41};
    req_pulse = '0;
    tx_busy   = 1'b0;
    ovf_clear = 1'b0;
    reset     = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 8'h00, 2'd0, 4'b0000, 4'b0000);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req_pulse = vecs[i].pulse;
      tx_busy   = vecs[i].busy;
      ovf_clear = vecs[i].clr;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].start, vecs[i].data, vecs[i].gid,
              vecs[i].pend, vecs[i].ovf);
    end
    req_pulse = '0;
    tx_busy   = 1'b0;
    ovf_clear = 1'b0;

    // All four channels at once, transmitter busy for 10 cycles starting
    // 2 cycles after each strobe; expect ch0..ch3 in order.
    exp_bytes = '{8'h41, 8'h42, 8'h43, 8'h44};
    start_cyc = -100;
    viol      = 0;
    in_frame  = 1'b0;
    seen_busy = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      req_pulse = (cyc == 0) ? 4'b1111 : 4'b0000;
      busy_now  = (cyc >= start_cyc + 2) && (cyc < start_cyc + 12);
      tx_busy   = busy_now;
      step();
      if (tx_start) begin
        if (in_frame) viol++;
        frames.push_back(tx_data);
        start_cyc = cyc;
        in_frame  = 1'b1;
        seen_busy = 1'b0;
      end else if (in_frame) begin
        if (busy_now) seen_busy = 1'b1;
        else if (seen_busy) in_frame = 1'b0;
      end
      if (frames.size() == 4 && !in_frame) break;
    end
    req_pulse = '0;
    tx_busy   = 1'b0;
    chk("burst frame count", 32'(frames.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < frames.size())
        chk($sformatf("burst frame%0d byte", k), 32'(frames[k]), 32'(exp_bytes[k]));
      else
        chk($sformatf("burst frame%0d missing", k), 32'd0, 32'd1);
    end
    chk("burst strobe during frame", 32'(viol), 32'd0);
    chk("burst pending drained", 32'(pending), 32'd0);

    // Reset in WAIT_DONE with ch1 pending discards everything.
    req_pulse = 4'b0001; step();
    req_pulse = 4'b0010; step();
    chk("rst seq grant ch0", 32'(tx_start), 32'd1);
    req_pulse = 4'b0000; tx_busy = 1'b1; step();
    chk("rst seq ch1 pending", 32'(pending), 32'b0010);
    reset = 1'b0; step();
    chk_all("midframe reset", 1'b0, 8'h00, 2'd0, 4'b0000, 4'b0000);
    reset = 1'b1; tx_busy = 1'b0; req_pulse = 4'b1000; step();
    chk("post-reset pending", 32'(pending), 32'b1000);
    chk("post-reset no early start", 32'(tx_start), 32'd0);
    req_pulse = 4'b0000; step();
    chk_all("post-reset grant", 1'b1, 8'h44, 2'd3, 4'b0000, 4'b0000);
    step();
    chk("post-reset strobe one cycle", 32'(tx_start), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
